// File: rtl/led_arb_pkg.sv
// rtl/led_arb_pkg.sv - shared types, sizes and round-robin pick for the LED mode arbiter
package led_arb_pkg;

    localparam int NUM_SRC = 4;
    localparam int LED_W   = 16;

    typedef enum logic [1:0] {IDLE, GRANT, SWITCH, BLANK} arb_state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // Searches from ptr+1 and wraps, so the index at ptr is considered last.
    function automatic pick_t rr_pick(input logic [NUM_SRC-1:0] req, input logic [1:0] ptr);
        pick_t      p;
        logic [1:0] cand;
        p.found = 1'b0;
        p.idx   = ptr;
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand = ptr + 2'(i);
            if (!p.found && req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/led_arb_tick.sv
// rtl/led_arb_tick.sv - free-running prescaler emitting a one-cycle tick every TICK_DIV cycles
module led_arb_tick #(
    parameter int TICK_DIV = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/led_mode_arbiter.sv
// rtl/led_mode_arbiter.sv - round-robin owner of the 16-LED bank with minimum dwell per grant
// Optional dark gap between modes: define LED_BLANK_EN.
module led_mode_arbiter
    import led_arb_pkg::*;
#(
    parameter int TICK_DIV   = 10000000,
    parameter int HOLD_TICKS = 5
) (
    input  logic                       clock_100mhz,
    input  logic                       reset_n,
    input  logic [NUM_SRC-1:0]         req,
    input  logic [NUM_SRC*LED_W-1:0]   led_src,
    output logic [LED_W-1:0]           led,
    output logic [NUM_SRC-1:0]         grant
);

    localparam logic [7:0] HOLD_MAX = 8'(HOLD_TICKS);

    arb_state_t       state;
    logic [1:0]       gidx;
    logic [1:0]       rr_ptr;
    logic [7:0]       hold_cnt;
    logic             tick;
    pick_t            pick;
    logic [LED_W-1:0] src_sel;
    logic             other_req;
    logic             hold_done;
    logic [NUM_SRC-1:0] pick_onehot;

    led_arb_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clock_100mhz),
        .rst_n (reset_n),
        .tick  (tick)
    );

    assign pick        = rr_pick(req, rr_ptr);
    assign pick_onehot = NUM_SRC'(1) << pick.idx;
    assign src_sel     = led_src[int'(gidx)*LED_W +: LED_W];
    assign other_req   = |(req & ~grant);
    assign hold_done   = (hold_cnt == HOLD_MAX);

    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            led      <= '0;
            grant    <= '0;
            gidx     <= '0;
            rr_ptr   <= 2'd3;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    led   <= '0;
                    grant <= '0;
                    if (pick.found) begin
                        grant    <= pick_onehot;
                        gidx     <= pick.idx;
                        rr_ptr   <= pick.idx;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (tick && !hold_done) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
`ifdef LED_BLANK_EN
                    if (!req[gidx] || (hold_done && other_req)) begin
                        led   <= '0;
                        grant <= '0;
                        state <= BLANK;
                    end else begin
                        led <= src_sel;
                    end
`else
                    // A drop releases the bank at once; an expiry keeps the holder lit until the handover.
                    if (!req[gidx]) begin
                        led   <= '0;
                        grant <= '0;
                        state <= SWITCH;
                    end else begin
                        led <= src_sel;
                        if (hold_done && other_req) begin
                            state <= SWITCH;
                        end
                    end
`endif
                end
                SWITCH: begin
                    if (pick.found) begin
                        led      <= (grant != '0 && req[gidx]) ? src_sel : '0;
                        grant    <= pick_onehot;
                        gidx     <= pick.idx;
                        rr_ptr   <= pick.idx;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end else begin
                        led   <= '0;
                        grant <= '0;
                        state <= IDLE;
                    end
                end
                BLANK: begin
                    led   <= '0;
                    grant <= '0;
                    if (req == '0) begin
                        state <= IDLE;
                    end else if (tick) begin
                        grant    <= pick_onehot;
                        gidx     <= pick.idx;
                        rr_ptr   <= pick.idx;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                default: begin
                    led   <= '0;
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_mode_arbiter.sv
// tb/tb_led_mode_arbiter.sv - directed vector and sequence bench for led_mode_arbiter (TICK_DIV=4, HOLD_TICKS=2)
module tb_led_mode_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = 4'h0;
    logic [63:0] led_src = 64'h4444_3333_2222_1111;
    logic [15:0] led;
    logic [3:0]  grant;

    int checks = 0;
    int errors = 0;

    led_mode_arbiter #(.TICK_DIV(4), .HOLD_TICKS(2)) dut (
        .clock_100mhz (clk),
        .reset_n      (reset_n),
        .req          (req),
        .led_src      (led_src),
        .led          (led),
        .grant        (grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] src_a;
        logic [3:0]  exp_grant;
        logic [15:0] exp_led;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [3:0] r);
        reset_n = 1'b0;
        req     = r;
        led_src = 64'h4444_3333_2222_1111;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] vals[8];
        int         lens[8];
        int         nv, nl, len, bad, waited;
        logic [3:0] prev;

        vecs[0] = '{4'h0, 16'h1111, 4'h0, 16'h0000};
        vecs[1] = '{4'h1, 16'h1111, 4'h1, 16'h0000};
        vecs[2] = '{4'h1, 16'h1111, 4'h1, 16'h1111};
        vecs[3] = '{4'h1, 16'hABCD, 4'h1, 16'hABCD};
        vecs[4] = '{4'h0, 16'hABCD, 4'h0, 16'h0000};
        vecs[5] = '{4'h0, 16'h1111, 4'h0, 16'h0000};
        vecs[6] = '{4'h8, 16'h1111, 4'h8, 16'h0000};
        vecs[7] = '{4'h8, 16'h1111, 4'h8, 16'h4444};
        vecs[8] = '{4'hC, 16'h1111, 4'h8, 16'h4444};
        vecs[9] = '{4'h4, 16'h1111, 4'h0, 16'h0000};

        // Reset held with all requests active
        reset_n = 1'b0;
        req     = 4'hF;
        @(negedge clk);
        check("reset_grant", grant, 4'h0);
        check("reset_led", led, 16'h0);
        reset_n = 1'b1;
        @(negedge clk);
        check("first_grant", grant, 4'b0001);
        check("first_led_blank", led, 16'h0);
        @(negedge clk);
        check("second_grant", grant, 4'b0001);
        check("second_led", led, 16'h1111);

        // Vector table from a fresh reset
        do_reset(4'h0);
        for (int i = 0; i < 10; i++) begin
            req     = vecs[i].req;
            led_src = {16'h4444, 16'h3333, 16'h2222, vecs[i].src_a};
            @(negedge clk);
            check($sformatf("vec%0d_grant", i), grant, vecs[i].exp_grant);
            check($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
        end

        // Single requester C held indefinitely
        do_reset(4'b0100);
        led_src = 64'h4444_A5A5_2222_1111;
        repeat (2) @(negedge clk);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (grant !== 4'b0100 || led !== 16'hA5A5) bad++;
        end
        check("single_c_held_bad_cycles", bad, 0);

        // Round-robin with req=1011
        do_reset(4'b1011);
        prev = 4'h0; len = 0; nv = 0; nl = 0; bad = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (grant !== prev) begin
                if (prev != 4'h0 && nl < 8) begin lens[nl] = len; nl++; end
                if (grant != 4'h0 && nv < 8) begin vals[nv] = grant; nv++; end
                len = 0;
            end
            if (grant != 4'h0) len++;
            if (!(grant == 4'h0 || $onehot(grant))) bad++;
            prev = grant;
        end
        check("rr_not_onehot_cycles", bad, 0);
        check("rr_run_count_ok", (nv >= 4 && nl >= 3) ? 1 : 0, 1);
        if (nv >= 4) begin
            check("rr_seq0", vals[0], 4'b0001);
            check("rr_seq1", vals[1], 4'b0010);
            check("rr_seq2", vals[2], 4'b1000);
            check("rr_seq3", vals[3], 4'b0001);
        end
        for (int k = 0; k < 3 && k < nl; k++) begin
            check($sformatf("rr_dwell%0d_in_7_to_9", k), (lens[k] >= 7 && lens[k] <= 9) ? 1 : 0, 1);
        end

        // Holder B drops mid-hold while D requests
        do_reset(4'b0010);
        @(negedge clk);
        check("drop_grant_b", grant, 4'b0010);
        req = 4'b1010;
        repeat (2) @(negedge clk);
        req = 4'b1000;
        @(negedge clk);
        check("drop_release_grant", grant, 4'h0);
        check("drop_release_led", led, 16'h0);
        waited = 0; bad = 0;
        while (grant == 4'h0 && waited < 10) begin
            @(negedge clk);
            waited++;
            if (grant == 4'h0 && led !== 16'h0) bad++;
        end
        check("drop_new_grant", grant, 4'b1000);
        check("drop_gap_led_lit", bad, 0);
`ifdef LED_BLANK_EN
        check("drop_handover_cycles", waited, 4);
`else
        check("drop_handover_cycles", waited, 1);
`endif

        // Sole requester A drops, then returns
        do_reset(4'b0001);
        repeat (3) @(negedge clk);
        check("alldrop_led_before", led, 16'h1111);
        req = 4'h0;
        @(negedge clk);
        check("alldrop_grant1", grant, 4'h0);
        check("alldrop_led1", led, 16'h0);
        @(negedge clk);
        check("alldrop_grant2", grant, 4'h0);
        req = 4'b0001;
        @(negedge clk);
        check("alldrop_regrant", grant, 4'b0001);

        // Asynchronous reset pulse mid-grant
        do_reset(4'b0010);
        repeat (3) @(negedge clk);
        check("areset_pre_grant", grant, 4'b0010);
        check("areset_pre_led", led, 16'h2222);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("areset_grant", grant, 4'h0);
        check("areset_led", led, 16'h0);
        #2 reset_n = 1'b1;
        req = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check("areset_rr_ptr_restart", grant, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
